// File: rtl/bform_branch_decode_queue_if.sv
// Dispatch-side and issue-side handshake/payload bundle for the B-form branch decode queue.
interface bform_branch_decode_queue_if #(
  parameter int unsigned addressWidth            = 64,
  parameter int unsigned instructionWidth        = 32,
  parameter int unsigned PidSize                 = 20,
  parameter int unsigned TidSize                 = 16,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned instMinIdWidth          = 7,
  parameter int unsigned opcodeSize              = 12,
  parameter int unsigned funcUnitCodeSize        = 3,
  parameter int unsigned QueueDepth              = 4
) ();
  localparam int unsigned CountWidth = $clog2(QueueDepth + 1);

  logic                               flush_i;
  logic                               valid_i;
  logic                               ready_o;
  logic [25:0]                        instFormat_i;
  logic [instructionWidth-1:0]        instruction_i;
  logic [addressWidth-1:0]            instructionAddress_i;
  logic                               is64Bit_i;
  logic [PidSize-1:0]                 instructionPid_i;
  logic [TidSize-1:0]                 instructionTid_i;
  logic [instructionCounterWidth-1:0] instructionMajId_i;

  logic                               valid_o;
  logic                               ready_i;
  logic [opcodeSize-1:0]              opcode_o;
  logic [funcUnitCodeSize-1:0]        functionalUnitType_o;
  logic [4:0]                         BO_o;
  logic [4:0]                         BI_o;
  logic                               AA_o;
  logic                               LK_o;
  logic [addressWidth-1:0]            branchTarget_o;
  logic [addressWidth-1:0]            linkAddress_o;
  logic [addressWidth-1:0]            instructionAddress_o;
  logic                               is64Bit_o;
  logic [PidSize-1:0]                 instPid_o;
  logic [TidSize-1:0]                 instTid_o;
  logic [instructionCounterWidth-1:0] instMajId_o;
  logic [instMinIdWidth-1:0]          instMinId_o;
  logic [CountWidth-1:0]              count_o;

  modport slave (
    input  flush_i, valid_i, instFormat_i, instruction_i, instructionAddress_i, is64Bit_i,
           instructionPid_i, instructionTid_i, instructionMajId_i, ready_i,
    output ready_o, valid_o, opcode_o, functionalUnitType_o, BO_o, BI_o, AA_o, LK_o,
           branchTarget_o, linkAddress_o, instructionAddress_o, is64Bit_o,
           instPid_o, instTid_o, instMajId_o, instMinId_o, count_o
  );

  modport master (
    output flush_i, valid_i, instFormat_i, instruction_i, instructionAddress_i, is64Bit_i,
           instructionPid_i, instructionTid_i, instructionMajId_i, ready_i,
    input  ready_o, valid_o, opcode_o, functionalUnitType_o, BO_o, BI_o, AA_o, LK_o,
           branchTarget_o, linkAddress_o, instructionAddress_o, is64Bit_o,
           instPid_o, instTid_o, instMajId_o, instMinId_o, count_o
  );
endinterface

// File: rtl/bform_branch_decode_queue.sv
// Decodes B-form (bc) branches, cracks CTR-decrementing ones into two uops, and
// buffers the results in a small FIFO feeding the branch unit issue stage.
module bform_branch_decode_queue #(
  parameter int unsigned addressWidth            = 64,
  parameter int unsigned instructionWidth        = 32,
  parameter int unsigned PidSize                 = 20,
  parameter int unsigned TidSize                 = 16,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned instMinIdWidth          = 7,
  parameter int unsigned opcodeSize              = 12,
  parameter int unsigned funcUnitCodeSize        = 3,
  parameter int unsigned BranchUnitID            = 6,
  parameter int unsigned B                       = 2**1,
  parameter int unsigned QueueDepth              = 4
) (
  input logic                        clock_i,
  input logic                        reset_i,
  bform_branch_decode_queue_if.slave bus
);
  localparam int unsigned PtrWidth   = $clog2(QueueDepth);
  localparam int unsigned CountWidth = $clog2(QueueDepth + 1);
  localparam int unsigned IW         = instructionWidth;

  typedef struct packed {
    logic [opcodeSize-1:0]              opcode;
    logic [funcUnitCodeSize-1:0]        fu;
    logic [4:0]                         bo;
    logic [4:0]                         bi;
    logic                               aa;
    logic                               lk;
    logic [addressWidth-1:0]            target;
    logic [addressWidth-1:0]            link;
    logic [addressWidth-1:0]            addr;
    logic                               is64;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [instructionCounterWidth-1:0] maj_id;
    logic [instMinIdWidth-1:0]          min_id;
  } entry_t;

  // Field extraction uses big-endian instruction bit numbering (bit 0 = MSB)
  logic [5:0]              w_popcode;
  logic [4:0]              w_bo;
  logic [4:0]              w_bi;
  logic [13:0]             w_bd;
  logic                    w_aa;
  logic                    w_lk;
  logic [addressWidth-1:0] w_offset;
  logic [addressWidth-1:0] w_target_full;
  logic [addressWidth-1:0] w_link_full;
  logic [addressWidth-1:0] w_addr_mask;

  assign w_popcode = bus.instruction_i[IW-1  -: 6];
  assign w_bo      = bus.instruction_i[IW-7  -: 5];
  assign w_bi      = bus.instruction_i[IW-12 -: 5];
  assign w_bd      = bus.instruction_i[IW-17 -: 14];
  assign w_aa      = bus.instruction_i[IW-31];
  assign w_lk      = bus.instruction_i[IW-32];

  assign w_offset      = {{(addressWidth-16){w_bd[13]}}, w_bd, 2'b00};
  assign w_target_full = w_aa ? w_offset : bus.instructionAddress_i + w_offset;
  assign w_link_full   = bus.instructionAddress_i + addressWidth'(4);
  assign w_addr_mask   = bus.is64Bit_i ? '1 : addressWidth'(64'h0000_0000_FFFF_FFFF);

  logic [PtrWidth-1:0]   r_wr_ptr;
  logic [PtrWidth-1:0]   r_rd_ptr;
  logic [CountWidth-1:0] r_count;
  logic                  r_valid;
  entry_t                r_head;
  entry_t                r_mem [QueueDepth];

  logic [PtrWidth-1:0]   w_wr_ptr_next;
  logic [PtrWidth-1:0]   w_rd_ptr_next;
  logic [PtrWidth-1:0]   w_wr_ptr_p1;
  logic [CountWidth-1:0] w_count_next;
  logic                  w_valid_next;
  entry_t                w_head_next;
  entry_t                w_mem_next [QueueDepth];
  entry_t                w_entry0;
  entry_t                w_entry1;

  logic       w_ready;
  logic       w_accept;
  logic       w_take;
  logic       w_crack;
  logic       w_deq;
  logic [1:0] w_nwr;

  // Room for a worst-case two-entry crack keeps ready independent of the offered instruction
  assign w_ready     = (r_count <= CountWidth'(QueueDepth - 2));
  assign w_accept    = bus.valid_i & w_ready & ~bus.flush_i;
  assign w_take      = w_accept & (bus.instFormat_i == 26'(B)) & (w_popcode == 6'd16);
  assign w_crack     = ~w_bo[2];
  assign w_deq       = r_valid & bus.ready_i & ~bus.flush_i;
  assign w_nwr       = w_take ? (w_crack ? 2'd2 : 2'd1) : 2'd0;
  assign w_wr_ptr_p1 = r_wr_ptr + PtrWidth'(1);

  // Entry payloads; the second entry only differs in uop code and minor ID
  always_comb begin
    w_entry0        = '0;
    w_entry0.opcode = opcodeSize'({w_popcode, (w_crack ? 4'b0001 : 4'b0000), w_aa, w_lk});
    w_entry0.fu     = funcUnitCodeSize'(BranchUnitID);
    w_entry0.bo     = w_bo;
    w_entry0.bi     = w_bi;
    w_entry0.aa     = w_aa;
    w_entry0.lk     = w_lk;
    w_entry0.target = w_target_full & w_addr_mask;
    w_entry0.link   = w_link_full & w_addr_mask;
    w_entry0.addr   = bus.instructionAddress_i;
    w_entry0.is64   = bus.is64Bit_i;
    w_entry0.pid    = bus.instructionPid_i;
    w_entry0.tid    = bus.instructionTid_i;
    w_entry0.maj_id = bus.instructionMajId_i;
    w_entry0.min_id = '0;

    w_entry1        = w_entry0;
    w_entry1.opcode = opcodeSize'({w_popcode, 4'b0000, w_aa, w_lk});
    w_entry1.min_id = instMinIdWidth'(1);
  end

  // Queue next state; flush wins over any same-cycle enqueue or dequeue
  always_comb begin
    w_mem_next    = r_mem;
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_count_next  = r_count;
    if (bus.flush_i) begin
      w_wr_ptr_next = '0;
      w_rd_ptr_next = '0;
      w_count_next  = '0;
    end else begin
      if (w_take) begin
        w_mem_next[r_wr_ptr] = w_entry0;
        if (w_crack) begin
          w_mem_next[w_wr_ptr_p1] = w_entry1;
          w_wr_ptr_next           = r_wr_ptr + PtrWidth'(2);
        end else begin
          w_wr_ptr_next = w_wr_ptr_p1;
        end
      end
      if (w_deq) begin
        w_rd_ptr_next = r_rd_ptr + PtrWidth'(1);
      end
      w_count_next = r_count + CountWidth'(w_nwr) - CountWidth'(w_deq);
    end
    w_valid_next = (w_count_next != '0);
    w_head_next  = w_valid_next ? w_mem_next[w_rd_ptr_next] : '0;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
      for (int i = 0; i < int'(QueueDepth); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_valid  <= w_valid_next;
      r_head   <= w_head_next;
      r_mem    <= w_mem_next;
    end
  end

  assign bus.ready_o              = w_ready;
  assign bus.valid_o              = r_valid;
  assign bus.count_o              = r_count;
  assign bus.opcode_o             = r_head.opcode;
  assign bus.functionalUnitType_o = r_head.fu;
  assign bus.BO_o                 = r_head.bo;
  assign bus.BI_o                 = r_head.bi;
  assign bus.AA_o                 = r_head.aa;
  assign bus.LK_o                 = r_head.lk;
  assign bus.branchTarget_o       = r_head.target;
  assign bus.linkAddress_o        = r_head.link;
  assign bus.instructionAddress_o = r_head.addr;
  assign bus.is64Bit_o            = r_head.is64;
  assign bus.instPid_o            = r_head.pid;
  assign bus.instTid_o            = r_head.tid;
  assign bus.instMajId_o          = r_head.maj_id;
  assign bus.instMinId_o          = r_head.min_id;
endmodule
